// File: rtl/banked_mem_ctrl_pkg.sv
// Shared op encodings, controller states and bank-count helper for the banked memory controller.
package banked_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MEM  = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic int bank_count(input int sel_width);
        return 1 << sel_width;
    endfunction

endpackage

// File: rtl/banked_mem_ctrl_if.sv
// Request/response channel plus stack status between the datapath and the banked memory controller.
interface banked_mem_ctrl_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int BANK_SEL_WIDTH  = 3
) ();

    logic                                      req_valid;
    logic                                      req_ready;
    logic [1:0]                                req_op;
    logic [BANK_SEL_WIDTH+BANK_ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]                     req_wdata;

    logic                                      rsp_valid;
    logic                                      rsp_ready;
    logic [DATA_WIDTH-1:0]                     rsp_rdata;
    logic                                      rsp_err;

    logic [BANK_ADDR_WIDTH:0]                  sp;
    logic                                      stack_full;
    logic                                      stack_empty;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, sp, stack_full, stack_empty
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, sp, stack_full, stack_empty
    );

endinterface

// File: rtl/banked_mem_ctrl_mem_bank_sp.sv
// Single-port synchronous RAM bank; contents are never reset.
// Latency: read data valid after the enabling edge, held until the next enabled read.
// Backpressure: none, accesses happen whenever en is high.
module mem_bank_sp #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [BANK_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << BANK_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read register only moves on reads so the response data stays put while stalled.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_mem_ctrl.sv
// Banked memory controller: flat-address read/write plus a hardware stack in the top bank.
// Latency: accept on T0, bank access on T1, response valid after T1 (3 cycles per command minimum).
// Backpressure: holds the response until rsp_ready; req_ready is low outside IDLE.
module banked_mem_ctrl
    import banked_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int BANK_SEL_WIDTH  = 3
) (
    input  logic              clk,
    input  logic              rst,
    banked_mem_ctrl_if.slave  bus
);

    localparam int AW         = BANK_ADDR_WIDTH;
    localparam int SW         = BANK_SEL_WIDTH;
    localparam int NUM_BANKS  = bank_count(BANK_SEL_WIDTH);
    localparam int STACK_BANK = NUM_BANKS - 1;
    localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [AW-1:0]         off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [AW:0]           sp_q, sp_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_rd_q, rsp_rd_d;

    logic [NUM_BANKS-1:0]  bank_en;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [AW:0]           sp_dec;
    op_t                   req_op;

    assign sp_dec = sp_q - SP_ONE;
    assign req_op = op_t'(bus.req_op);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sel_d       = sel_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        sp_d        = sp_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rd_d    = rsp_rd_q;
        bank_en     = '0;
        bank_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = req_op;
                    wdata_d = bus.req_wdata;
                    err_d   = ((req_op == OP_PUSH) && (sp_q == SP_FULL)) ||
                              ((req_op == OP_POP)  && (sp_q == '0));
                    // Stack offset is resolved now; sp cannot move before the MEM cycle.
                    if (req_op == OP_PUSH) begin
                        sel_d = SW'(STACK_BANK);
                        off_d = sp_q[AW-1:0];
                    end else if (req_op == OP_POP) begin
                        sel_d = SW'(STACK_BANK);
                        off_d = sp_dec[AW-1:0];
                    end else begin
                        sel_d = bus.req_addr[AW+SW-1:AW];
                        off_d = bus.req_addr[AW-1:0];
                    end
                    state_d = MEM;
                end
            end
            MEM: begin
                if (!err_q) begin
                    bank_en[sel_q] = 1'b1;
                    bank_we        = (op_q == OP_WRITE) || (op_q == OP_PUSH);
                    if (op_q == OP_PUSH) begin
                        sp_d = sp_q + SP_ONE;
                    end else if (op_q == OP_POP) begin
                        sp_d = sp_dec;
                    end
                end
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_rd_d    = !err_q && ((op_q == OP_READ) || (op_q == OP_POP));
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rd_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_READ;
            sel_q       <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            sp_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            sp_q        <= sp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank_sp #(
            .DATA_WIDTH      (DATA_WIDTH),
            .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (bank_we),
            .addr  (off_q),
            .wdata (wdata_q),
            .rdata (bank_rdata[b])
        );
    end

    // sel_q stays fixed through RESP, so the muxed read data is stable while stalled.
    assign bus.rsp_rdata   = rsp_rd_q ? bank_rdata[sel_q] : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.sp          = sp_q;
    assign bus.stack_full  = (sp_q == SP_FULL);
    assign bus.stack_empty = (sp_q == '0);

endmodule

// File: doc/banked_mem_ctrl.md
# banked_mem_ctrl

Parametrised, handshaked memory subsystem for the LEGv8 datapath, replacing the fixed eight-bank tri-state RAM array with a sequenced controller. It decodes a flat word address into 2**BANK_SEL_WIDTH single-port synchronous banks and performs reads and writes. The top bank doubles as a hardware stack with an internal stack pointer, push/pop operations and full/empty detection. It sits between the control unit/ALU address path and the data bus; responses are returned through a ready/valid channel, with no bidirectional bus.

## Interface
- DATA_WIDTH, 64, word width of every bank and of the data ports
- BANK_ADDR_WIDTH, 12, word-address width inside one bank; bank depth DEPTH = 2**BANK_ADDR_WIDTH
- BANK_SEL_WIDTH, 3, bank-select width; NUM_BANKS = 2**BANK_SEL_WIDTH; bank NUM_BANKS-1 is the stack bank
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  controller can accept a command
- req_op  in  2  00 READ, 01 WRITE, 10 PUSH, 11 POP
- req_addr  in  BANK_SEL_WIDTH+BANK_ADDR_WIDTH  flat address; upper BANK_SEL_WIDTH bits select the bank; ignored for PUSH/POP
- req_wdata  in  DATA_WIDTH  write/push data
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_WIDTH  read/pop data; 0 for WRITE/PUSH and on error
- rsp_err  out  1  PUSH when full or POP when empty
- sp  out  BANK_ADDR_WIDTH+1  stack pointer, the number of entries in the stack
- stack_full  out  1  sp == DEPTH
- stack_empty  out  1  sp == 0

## Operation
- FSM states: IDLE, MEM, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid, latch op, addr and wdata, evaluate the error condition, go to MEM.
- MEM: exactly one bank is enabled.
  - WRITE: commits req_wdata at the selected bank and offset.
  - READ: issues a synchronous read.
  - PUSH (not full): writes to stack bank offset sp[BANK_ADDR_WIDTH-1:0]; sp increments.
  - POP (not empty): reads stack bank offset sp-1; sp decrements.
  - Erroring op: no bank enabled; sp unchanged.
  - Always go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1, then return to IDLE.
- READ/WRITE on the stack bank by address are legal and do not alter sp.
- stack_full and stack_empty are combinational from sp.
- sp changes only in MEM, never by more than one per command.
- Async reset: state=IDLE, sp=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Therefore req_ready=1, stack_empty=1, stack_full=0. Bank contents are not cleared.
- Reset asserted in MEM or RESP aborts the command with no response. A write in the same edge as reset assertion is not guaranteed.

## Timing
- Accept edge T0 (req_valid and req_ready).
- Bank access on edge T1.
- rsp_valid high from after T1; earliest completion is edge T2 when rsp_ready is already high.
- Throughput: one command per 3 cycles at best.
- rsp_ready held low stalls in RESP indefinitely; req_ready stays low meanwhile.
- Read data is registered; rsp_rdata never changes while rsp_valid=1 and rsp_ready=0.
- sp updates on edge T1 and is visible in the RESP cycle.

## Structure
- Package banked_mem_pkg:
  - op encodings OP_READ, OP_WRITE, OP_PUSH, OP_POP
  - state enum IDLE/MEM/RESP
  - helper constant for bank count from BANK_SEL_WIDTH
- Sub-module mem_bank_sp: single-port synchronous RAM (clk, en, we, addr, wdata, rdata), parametrised DATA_WIDTH and BANK_ADDR_WIDTH. NUM_BANKS instances are built by a generate loop.
- Bank read data is muxed by the registered bank select.

## Test plan
- Reset mid-stall: reset while in RESP -> rsp_valid=0, req_ready=1 and sp=0 immediately (asynchronous); the next command is accepted normally.
- Write then read: WRITE addr 0x1005, data 0xDEAD_BEEF_0000_0001; then READ 0x1005 -> rsp_rdata=0xDEAD_BEEF_0000_0001, rsp_err=0. READ 0x0005 returns different prior contents (bank isolation).
- Handshake stall: READ with rsp_ready held low for 5 cycles -> rsp_valid stays 1, data stable, req_ready=0. rsp_ready=1 -> back to IDLE the next cycle.
- Stack LIFO (BANK_ADDR_WIDTH=4): PUSH 1,2,3 -> sp=3. POP,POP,POP -> 3,2,1, sp=0, stack_empty=1.
- Overflow: 16 PUSHes -> stack_full=1. A 17th PUSH -> rsp_err=1, sp stays 16, and a READ of stack offset 0 still returns the first pushed value.
- Underflow: POP at sp=0 -> rsp_err=1, rsp_rdata=0, sp=0.
- Direct stack access: WRITE to the stack bank at offset 2 while sp=3 -> sp unchanged; the next POP returns the written value.
